// File: rtl/seq_pkg.sv
// Shared sequencer definitions: op-field encodings used by the sequencer,
// the CPU microcode field decode and the microassembler tables.
package seq_pkg;

  localparam int SEQ_OP_W = 4;

  localparam logic [SEQ_OP_W-1:0] SEQ_NEXT  = 4'd0;
  localparam logic [SEQ_OP_W-1:0] SEQ_JUMP  = 4'd1;
  localparam logic [SEQ_OP_W-1:0] SEQ_MAP   = 4'd2;
  localparam logic [SEQ_OP_W-1:0] SEQ_CALL  = 4'd3;
  localparam logic [SEQ_OP_W-1:0] SEQ_RET   = 4'd4;
  localparam logic [SEQ_OP_W-1:0] SEQ_CJUMP = 4'd5;
  localparam logic [SEQ_OP_W-1:0] SEQ_CCALL = 4'd6;
  localparam logic [SEQ_OP_W-1:0] SEQ_CRET  = 4'd7;
  localparam logic [SEQ_OP_W-1:0] SEQ_LDCNT = 4'd8;
  localparam logic [SEQ_OP_W-1:0] SEQ_LOOP  = 4'd9;
  localparam logic [SEQ_OP_W-1:0] SEQ_HOLD  = 4'd10;

endpackage

// File: rtl/seq_stack.sv
// Return-address LIFO for the microsequencer. Top-of-stack is read
// combinationally so a return can redirect the uPC in the same cycle.
// Push on full and pop on empty leave the pointer alone and raise sticky
// error flags that only reset clears.
module seq_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 12
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] push_data_i,
  output logic [W-1:0] top_o,
  output logic         full_o,
  output logic         empty_o,
  output logic         overflow_o,
  output logic         underflow_o
);

  // Pointer must represent 0..DEPTH; index covers 0..DEPTH-1.
  localparam int SP_W  = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [SP_W-1:0]  sp_q;
  logic             overflow_q;
  logic             underflow_q;
  logic [SP_W-1:0]  sp_m1;
  logic [IDX_W-1:0] top_idx;
  logic [IDX_W-1:0] wr_idx;

  assign full_o      = (sp_q == SP_W'(DEPTH));
  assign empty_o     = (sp_q == '0);
  assign overflow_o  = overflow_q;
  assign underflow_o = underflow_q;

  assign sp_m1   = sp_q - SP_W'(1);
  assign top_idx = sp_m1[IDX_W-1:0];
  assign wr_idx  = sp_q[IDX_W-1:0];
  assign top_o   = empty_o ? '0 : mem_q[top_idx];

  // Entry storage: written only on a push that has room; contents never reset.
  always_ff @(posedge clock) begin
    if (push_i && !full_o) begin
      mem_q[wr_idx] <= push_data_i;
    end
  end

  // Stack pointer and sticky error flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      sp_q        <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (push_i) begin
      if (full_o) overflow_q <= 1'b1;
      else        sp_q       <= sp_q + SP_W'(1);
    end else if (pop_i) begin
      if (empty_o) underflow_q <= 1'b1;
      else         sp_q        <= sp_m1;
    end
  end

endmodule

// File: rtl/microsequencer.sv
// Microprogram sequencer: registered uPC selected each cycle from the op
// field, with return stack, conditional ops, loop counter and stall.
module microsequencer
  import seq_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter int STACK_DEPTH = 4,
  parameter int COND_W      = 8,
  parameter int CNT_W       = 8,
  localparam int SEL_W      = (COND_W > 1) ? $clog2(COND_W) : 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [SEQ_OP_W-1:0] op,
  input  logic [ADDR_W-1:0]   din,
  input  logic [ADDR_W-1:0]   map_addr,
  input  logic [COND_W-1:0]   cond,
  input  logic [SEL_W-1:0]    cond_sel,
  input  logic                cond_pol,
  input  logic                stall,
  output logic [ADDR_W-1:0]   address,
  output logic [CNT_W-1:0]    loop_count,
  output logic                stack_empty,
  output logic                stack_full,
  output logic                overflow,
  output logic                underflow
);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] inc;
  logic [ADDR_W-1:0] top;
  logic              taken;
  logic              push_req, pop_req;

  assign inc        = addr_q + ADDR_W'(1);
  assign taken      = (cond[cond_sel] == cond_pol);
  assign address    = addr_q;
  assign loop_count = cnt_q;

  seq_stack #(
    .DEPTH (STACK_DEPTH),
    .W     (ADDR_W)
  ) u_stack (
    .clock       (clock),
    .reset       (reset),
    .push_i      (push_req & ~stall),
    .pop_i       (pop_req & ~stall),
    .push_data_i (inc),
    .top_o       (top),
    .full_o      (stack_full),
    .empty_o     (stack_empty),
    .overflow_o  (overflow),
    .underflow_o (underflow)
  );

  // Next-address selection, stack strobes and loop-counter update.
  // A pop on an empty stack still strobes the stack (to flag underflow)
  // but falls through to inc; a push on a full stack still jumps.
  always_comb begin
    addr_d   = inc;
    cnt_d    = cnt_q;
    push_req = 1'b0;
    pop_req  = 1'b0;
    case (op)
      SEQ_JUMP: addr_d = din;
      SEQ_MAP:  addr_d = map_addr;
      SEQ_CALL: begin
        push_req = 1'b1;
        addr_d   = din;
      end
      SEQ_RET: begin
        pop_req = 1'b1;
        addr_d  = stack_empty ? inc : top;
      end
      SEQ_CJUMP: addr_d = taken ? din : inc;
      SEQ_CCALL: begin
        if (taken) begin
          push_req = 1'b1;
          addr_d   = din;
        end
      end
      SEQ_CRET: begin
        if (taken) begin
          pop_req = 1'b1;
          addr_d  = stack_empty ? inc : top;
        end
      end
      SEQ_LDCNT: cnt_d = din[CNT_W-1:0];
      SEQ_LOOP: begin
        if (cnt_q != '0) begin
          cnt_d  = cnt_q - CNT_W'(1);
          addr_d = din;
        end
      end
      SEQ_HOLD: addr_d = addr_q;
      default:  addr_d = inc;
    endcase
  end

  // uPC and loop counter; reset overrides stall, stall freezes everything.
  always_ff @(posedge clock) begin
    if (reset) begin
      addr_q <= '0;
      cnt_q  <= '0;
    end else if (!stall) begin
      addr_q <= addr_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: tb/tb_microsequencer.sv
// Directed bench for microsequencer: hand-computed expected uPC, counter
// and stack flags after each edge.
module tb_microsequencer;
  import seq_pkg::*;

  logic          clock = 1'b0;
  logic          reset;
  logic [3:0]    op;
  logic [11:0]   din;
  logic [11:0]   map_addr;
  logic [7:0]    cond;
  logic [2:0]    cond_sel;
  logic          cond_pol;
  logic          stall;
  logic [11:0]   address;
  logic [7:0]    loop_count;
  logic          stack_empty;
  logic          stack_full;
  logic          overflow;
  logic          underflow;

  int n_cmp = 0;
  int n_bad = 0;

  microsequencer #(
    .ADDR_W      (12),
    .STACK_DEPTH (4),
    .COND_W      (8),
    .CNT_W       (8)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .op          (op),
    .din         (din),
    .map_addr    (map_addr),
    .cond        (cond),
    .cond_sel    (cond_sel),
    .cond_pol    (cond_pol),
    .stall       (stall),
    .address     (address),
    .loop_count  (loop_count),
    .stack_empty (stack_empty),
    .stack_full  (stack_full),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Apply one op for one clock edge, then sample 1 time unit later.
  task automatic step(input logic [3:0] o, input logic [11:0] d);
    op  = o;
    din = d;
    @(posedge clock);
    #1;
    $display("op=%0d din=0x%03h stall=%0b reset=%0b -> address=0x%03h cnt=%0d sp_empty=%0b sp_full=%0b ovf=%0b unf=%0b",
             o, d, stall, reset, address, loop_count, stack_empty, stack_full, overflow, underflow);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(SEQ_NEXT, 12'h000);
    step(SEQ_NEXT, 12'h000);
    reset = 1'b0;
  endtask

  task automatic check_flags(input string tag, input logic e, input logic f,
                             input logic ov, input logic un);
    check({tag, ".empty"}, 32'(stack_empty), 32'(e));
    check({tag, ".full"},  32'(stack_full),  32'(f));
    check({tag, ".ovf"},   32'(overflow),    32'(ov));
    check({tag, ".unf"},   32'(underflow),   32'(un));
  endtask

  initial begin
    reset    = 1'b1;
    op       = SEQ_NEXT;
    din      = '0;
    map_addr = '0;
    cond     = '0;
    cond_sel = '0;
    cond_pol = 1'b0;
    stall    = 1'b0;

    // Reset state
    do_reset();
    check("rst.addr", 32'(address), 32'h000);
    check("rst.cnt",  32'(loop_count), 32'h0);
    check_flags("rst", 1'b1, 1'b0, 1'b0, 1'b0);

    // Sequential NEXT
    for (int i = 1; i <= 5; i++) begin
      step(SEQ_NEXT, 12'h000);
      check("next.addr", 32'(address), 32'(i));
    end
    check_flags("next", 1'b1, 1'b0, 1'b0, 1'b0);

    // JUMP / CALL / NEXT / RET
    step(SEQ_JUMP, 12'h100); check("jump.addr", 32'(address), 32'h100);
    step(SEQ_CALL, 12'h200); check("call.addr", 32'(address), 32'h200);
    check("call.empty", 32'(stack_empty), 32'h0);
    step(SEQ_NEXT, 12'h000); check("call.next", 32'(address), 32'h201);
    step(SEQ_RET,  12'h000); check("ret.addr",  32'(address), 32'h101);
    check("ret.empty", 32'(stack_empty), 32'h1);

    // Nested calls past the stack depth, then unwind past empty
    step(SEQ_CALL, 12'h300); check("nest1", 32'(address), 32'h300);
    step(SEQ_CALL, 12'h310); check("nest2", 32'(address), 32'h310);
    step(SEQ_CALL, 12'h320); check("nest3", 32'(address), 32'h320);
    step(SEQ_CALL, 12'h330); check("nest4", 32'(address), 32'h330);
    check_flags("nest4", 1'b0, 1'b1, 1'b0, 1'b0);
    step(SEQ_CALL, 12'h340); check("nest5", 32'(address), 32'h340);
    check_flags("nest5", 1'b0, 1'b1, 1'b1, 1'b0);
    step(SEQ_RET, 12'h000); check("unw1", 32'(address), 32'h321);
    step(SEQ_RET, 12'h000); check("unw2", 32'(address), 32'h311);
    step(SEQ_RET, 12'h000); check("unw3", 32'(address), 32'h301);
    step(SEQ_RET, 12'h000); check("unw4", 32'(address), 32'h102);
    check_flags("unw4", 1'b1, 1'b0, 1'b1, 1'b0);
    step(SEQ_RET, 12'h000); check("unw5", 32'(address), 32'h103);
    check_flags("unw5", 1'b1, 1'b0, 1'b1, 1'b1);

    // Reset clears sticky flags
    do_reset();
    check("rst2.addr", 32'(address), 32'h000);
    check_flags("rst2", 1'b1, 1'b0, 1'b0, 1'b0);

    // Loop counter: load 3, body at 0x011 visited 4 times
    step(SEQ_JUMP,  12'h010); check("lp.jump", 32'(address), 32'h010);
    step(SEQ_LDCNT, 12'h003); check("lp.ld.addr", 32'(address), 32'h011);
    check("lp.ld.cnt", 32'(loop_count), 32'd3);
    step(SEQ_LOOP, 12'h011); check("lp1.addr", 32'(address), 32'h011);
    check("lp1.cnt", 32'(loop_count), 32'd2);
    step(SEQ_LOOP, 12'h011); check("lp2.addr", 32'(address), 32'h011);
    check("lp2.cnt", 32'(loop_count), 32'd1);
    step(SEQ_LOOP, 12'h011); check("lp3.addr", 32'(address), 32'h011);
    check("lp3.cnt", 32'(loop_count), 32'd0);
    step(SEQ_LOOP, 12'h011); check("lp4.addr", 32'(address), 32'h012);
    check("lp4.cnt", 32'(loop_count), 32'd0);

    // Conditional ops: cond[2]=1
    cond = 8'h04; cond_sel = 3'd2;
    cond_pol = 1'b1;
    step(SEQ_CJUMP, 12'h050); check("cj.t", 32'(address), 32'h050);
    cond_pol = 1'b0;
    step(SEQ_CJUMP, 12'h060); check("cj.f", 32'(address), 32'h051);
    step(SEQ_CRET,  12'h000); check("cr.f", 32'(address), 32'h052);
    check_flags("cr.f", 1'b1, 1'b0, 1'b0, 1'b0);
    step(SEQ_CCALL, 12'h070); check("cc.f", 32'(address), 32'h053);
    check("cc.f.empty", 32'(stack_empty), 32'h1);
    cond_pol = 1'b1;
    step(SEQ_CCALL, 12'h070); check("cc.t", 32'(address), 32'h070);
    check("cc.t.empty", 32'(stack_empty), 32'h0);
    step(SEQ_CRET,  12'h000); check("cr.t", 32'(address), 32'h054);
    check("cr.t.empty", 32'(stack_empty), 32'h1);

    // Address wrap
    step(SEQ_JUMP, 12'hFFF); check("wrap.jump", 32'(address), 32'hFFF);
    step(SEQ_NEXT, 12'h000); check("wrap.next", 32'(address), 32'h000);

    // Stall freezes a pending CALL
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(SEQ_CALL, 12'h200);
      check("stall.addr",  32'(address), 32'h000);
      check("stall.empty", 32'(stack_empty), 32'h1);
    end
    stall = 1'b0;
    step(SEQ_CALL, 12'h200); check("unstall.addr", 32'(address), 32'h200);
    check("unstall.empty", 32'(stack_empty), 32'h0);
    step(SEQ_HOLD, 12'h000); check("hold.addr", 32'(address), 32'h200);
    check("hold.empty", 32'(stack_empty), 32'h0);

    // Reset wins over stall
    stall = 1'b1; reset = 1'b1;
    step(SEQ_JUMP, 12'h555); check("rststall.addr", 32'(address), 32'h000);
    check("rststall.empty", 32'(stack_empty), 32'h1);
    stall = 1'b0; reset = 1'b0;

    // MAP
    map_addr = 12'h3A5;
    step(SEQ_MAP, 12'h000); check("map.addr", 32'(address), 32'h3A5);

    // Reserved op behaves as NEXT
    step(4'd13, 12'h777); check("rsvd.addr", 32'(address), 32'h3A6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
